// File: rtl/inst_prog_mem_pkg.sv
// Shared types and constants for the instruction program memory:
// FSM state encoding, default geometry and the halt-word helper.
package inst_prog_mem_pkg;

  localparam int DEF_A = 10;
  localparam int DEF_W = 9;
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // All-ones word of width w, returned in the low bits of a MAX_W vector
  function automatic logic [MAX_W-1:0] HALT_WORD(input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Single-port synchronous RAM with registered read data; contents are
// never reset, so it maps onto block RAM.
module inst_mem_array #(
  parameter int A  = 10,
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [A-1:0]  addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**A];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/inst_prog_mem.sv
// Loadable instruction program memory with IDLE/LOAD/RUN control and a
// one-cycle registered fetch. Define INST_PARITY_EN to store an even-parity bit per word.
module inst_prog_mem
  import inst_prog_mem_pkg::*;
#(
  parameter int A = DEF_A,
  parameter int W = DEF_W
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         LoadStart,
  input  logic [W-1:0] LoadData,
  input  logic         LoadValid,
  input  logic         LoadLast,
  output logic         LoadReady,
  output logic         LoadDone,
  output logic [A:0]   LoadCount,
  input  logic         FetchReq,
  input  logic [A-1:0] InstAddress,
  output logic [W-1:0] InstOut,
  output logic         InstValid,
  output logic         ParityErr
);

`ifdef INST_PARITY_EN
  localparam int DW = W + 1;
`else
  localparam int DW = W;
`endif

  localparam logic [MAX_W-1:0] HALT_FULL = HALT_WORD(W);
  localparam logic [W-1:0]     HALT      = HALT_FULL[W-1:0];
  localparam logic [A-1:0]     PTR_MAX   = '1;
  localparam logic [A-1:0]     PTR_ONE   = A'(1);
  localparam logic [A:0]       CNT_ONE   = (A+1)'(1);

  state_e         state_q, state_d;
  logic [A-1:0]   ptr_q, ptr_d;
  logic [A:0]     count_q, count_d;
  logic           done_q, done_d;
  logic           valid_q, valid_d;
  logic           halt_q, halt_d;
  logic [W-1:0]   hold_q;

  logic           mem_we;
  logic [A-1:0]   mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata;
  logic [W-1:0]   rd_word;

`ifdef INST_PARITY_EN
  assign mem_wdata = {^LoadData, LoadData};
  assign ParityErr = valid_q & ~halt_q & (^mem_rdata);
`else
  assign mem_wdata = LoadData;
  assign ParityErr = 1'b0;
`endif

  inst_mem_array #(.A(A), .DW(DW)) u_mem (
    .clk     (Clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    done_d   = 1'b0;
    valid_d  = 1'b0;
    halt_d   = halt_q;
    mem_we   = (state_q == ST_LOAD) && LoadValid;
    mem_addr = (state_q == ST_LOAD) ? ptr_q : InstAddress;
    if (LoadStart) begin
      state_d = ST_LOAD;
      ptr_d   = '0;
      count_d = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (LoadValid) begin
            count_d = count_q + CNT_ONE;
            // Pointer saturates at the top word; the FSM leaves LOAD on that beat
            if (ptr_q != PTR_MAX) ptr_d = ptr_q + PTR_ONE;
            if (LoadLast || (ptr_q == PTR_MAX)) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (FetchReq) begin
            valid_d = 1'b1;
            halt_d  = ({1'b0, InstAddress} >= count_q);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      halt_q  <= halt_d;
      if (valid_q) hold_q <= InstOut;
    end
  end

  // RAM output is live only in the cycle after a fetch; otherwise replay the last result
  assign rd_word   = halt_q ? HALT : mem_rdata[W-1:0];
  assign InstOut   = valid_q ? rd_word : hold_q;
  assign InstValid = valid_q;
  assign LoadReady = (state_q == ST_LOAD);
  assign LoadDone  = done_q;
  assign LoadCount = count_q;

endmodule

// File: tb/tb_inst_prog_mem.sv
// Self-checking bench for inst_prog_mem (A=3, W=9): directed table,
// corner-case sequences and randomized traffic against a queue-based model.
module tb_inst_prog_mem;

  localparam int A = 3;
  localparam int W = 9;
  localparam int DEPTH = 8;
`ifdef INST_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         LoadStart = 1'b0;
  logic [W-1:0] LoadData = '0;
  logic         LoadValid = 1'b0;
  logic         LoadLast = 1'b0;
  logic         LoadReady;
  logic         LoadDone;
  logic [A:0]   LoadCount;
  logic         FetchReq = 1'b0;
  logic [A-1:0] InstAddress = '0;
  logic [W-1:0] InstOut;
  logic         InstValid;
  logic         ParityErr;

  inst_prog_mem #(.A(A), .W(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .LoadStart(LoadStart), .LoadData(LoadData),
    .LoadValid(LoadValid), .LoadLast(LoadLast), .LoadReady(LoadReady),
    .LoadDone(LoadDone), .LoadCount(LoadCount), .FetchReq(FetchReq),
    .InstAddress(InstAddress), .InstOut(InstOut), .InstValid(InstValid),
    .ParityErr(ParityErr)
  );

  initial forever #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: program is the queue of accepted words; mode 0 idle, 1 loading, 2 running
  int           mode = 0;
  logic [W-1:0] prog[$];
  logic         corrupt0 = 1'b0;
  logic         exp_done = 1'b0, exp_valid = 1'b0, exp_perr = 1'b0;
  logic [W-1:0] exp_out = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic ls, input logic lv, input logic [W-1:0] d,
                        input logic ll, input logic fr, input logic [A-1:0] ad);
    LoadStart = ls; LoadValid = lv; LoadData = d; LoadLast = ll;
    FetchReq = fr; InstAddress = ad;
  endtask

  task automatic cyc(input string tag);
    exp_done = 1'b0; exp_valid = 1'b0; exp_perr = 1'b0;
    if (LoadStart) begin
      mode = 1;
      prog.delete();
    end else if (mode == 1) begin
      if (LoadValid) begin
        prog.push_back(LoadData);
        if (prog.size() == 1) corrupt0 = 1'b0;
        if (LoadLast || prog.size() == DEPTH) begin
          mode = 2;
          exp_done = 1'b1;
        end
      end
    end else if (mode == 2 && FetchReq) begin
      exp_valid = 1'b1;
      if (int'(InstAddress) < prog.size()) begin
        exp_out  = prog[InstAddress];
        exp_perr = PAR_EN && (InstAddress == 0) && corrupt0;
      end else begin
        exp_out = '1;
      end
    end
    @(posedge Clk); #1;
    chk({tag, ".ready"}, 32'(LoadReady), 32'(mode == 1));
    chk({tag, ".done"},  32'(LoadDone),  32'(exp_done));
    chk({tag, ".count"}, 32'(LoadCount), prog.size());
    chk({tag, ".valid"}, 32'(InstValid), 32'(exp_valid));
    chk({tag, ".out"},   32'(InstOut),   32'(exp_out));
    chk({tag, ".perr"},  32'(ParityErr), 32'(exp_perr));
    $display("cyc %-8s ls=%0d lv=%0d d=%03h ll=%0d fr=%0d a=%0d -> rdy=%0d done=%0d cnt=%0d v=%0d out=%03h perr=%0d",
             tag, LoadStart, LoadValid, LoadData, LoadLast, FetchReq, InstAddress,
             LoadReady, LoadDone, LoadCount, InstValid, InstOut, ParityErr);
  endtask

  typedef struct {
    logic         ls, lv, ll, fr;
    logic [W-1:0] d;
    logic [A-1:0] ad;
    logic         e_done, e_valid, ck_out;
    logic [W-1:0] e_out;
    logic [A:0]   e_cnt;
  } vec_t;

  vec_t tv[13];
  logic [W-1:0] tmp;

  initial begin
    //        ls lv ll fr  data    ad  done valid ckout out      cnt
    tv[0]  = '{1, 0, 0, 0, 9'h000, 0,  0,   0,    0,   9'h000, 0};
    tv[1]  = '{0, 1, 0, 0, 9'h0C8, 0,  0,   0,    0,   9'h000, 1};
    tv[2]  = '{0, 1, 0, 0, 9'h0DC, 0,  0,   0,    0,   9'h000, 2};
    tv[3]  = '{0, 1, 0, 0, 9'h00B, 0,  0,   0,    0,   9'h000, 3};
    tv[4]  = '{0, 1, 1, 0, 9'h188, 0,  1,   0,    0,   9'h000, 4};
    tv[5]  = '{0, 0, 0, 0, 9'h000, 0,  0,   0,    0,   9'h000, 4};
    tv[6]  = '{0, 0, 0, 1, 9'h000, 2,  0,   1,    1,   9'h00B, 4};
    tv[7]  = '{0, 0, 0, 1, 9'h000, 7,  0,   1,    1,   9'h1FF, 4};
    tv[8]  = '{0, 0, 0, 1, 9'h000, 0,  0,   1,    1,   9'h0C8, 4};
    tv[9]  = '{0, 0, 0, 1, 9'h000, 1,  0,   1,    1,   9'h0DC, 4};
    tv[10] = '{0, 0, 0, 1, 9'h000, 2,  0,   1,    1,   9'h00B, 4};
    tv[11] = '{0, 0, 0, 1, 9'h000, 3,  0,   1,    1,   9'h188, 4};
    tv[12] = '{0, 0, 0, 0, 9'h000, 0,  0,   0,    1,   9'h188, 4};

    // Power-on reset
    repeat (3) @(posedge Clk);
    #1;
    chk("rst.ready", 32'(LoadReady), 0);
    chk("rst.done",  32'(LoadDone),  0);
    chk("rst.count", 32'(LoadCount), 0);
    chk("rst.valid", 32'(InstValid), 0);
    chk("rst.out",   32'(InstOut),   0);
    chk("rst.perr",  32'(ParityErr), 0);
    Reset_n = 1'b1;

    // Load four words and fetch them, including halt and back-to-back streaming
    for (int i = 0; i < 13; i++) begin
      set_in(tv[i].ls, tv[i].lv, tv[i].d, tv[i].ll, tv[i].fr, tv[i].ad);
      cyc($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.done", i),  32'(LoadDone),  32'(tv[i].e_done));
      chk($sformatf("tbl%0d.count", i), 32'(LoadCount), 32'(tv[i].e_cnt));
      chk($sformatf("tbl%0d.valid", i), 32'(InstValid), 32'(tv[i].e_valid));
      if (tv[i].ck_out) chk($sformatf("tbl%0d.out", i), 32'(InstOut), 32'(tv[i].e_out));
    end

    // Fill to full depth with gapped LoadValid and no LoadLast
    set_in(1, 0, 0, 0, 0, 0); cyc("fill.st");
    for (int b = 0; b < 16; b++) begin
      set_in(0, (b % 2) == 0, W'($urandom), 0, 0, 0);
      cyc("fill");
      if (b == 14) begin
        chk("fill.done8", 32'(LoadDone), 1);
        chk("fill.cnt8", 32'(LoadCount), 8);
        chk("fill.rdy8", 32'(LoadReady), 0);
      end
    end
    set_in(0, 1, 9'h055, 0, 0, 0); cyc("fill.9th");
    chk("fill.cnt9", 32'(LoadCount), 8);
    set_in(0, 0, 0, 0, 1, 7); cyc("fill.rd7");

    // Restart abandons a partial load
    set_in(1, 0, 0, 0, 0, 0); cyc("rs.st1");
    for (int b = 0; b < 3; b++) begin
      set_in(0, 1, W'($urandom), 0, 0, 0); cyc("rs.ld3");
    end
    set_in(1, 0, 0, 0, 0, 0); cyc("rs.st2");
    set_in(0, 1, 9'h123, 0, 0, 0); cyc("rs.ld2");
    set_in(0, 1, 9'h0F0, 1, 0, 0); cyc("rs.ld2");
    chk("rs.count", 32'(LoadCount), 2);
    set_in(0, 0, 0, 0, 1, 2); cyc("rs.rd2");
    chk("rs.halt", 32'(InstOut), 32'h1FF);

    // Corrupt stored word 0 and fetch it
    dut.u_mem.mem_q[0][0] = ~dut.u_mem.mem_q[0][0];
    tmp = prog[0]; tmp[0] = ~tmp[0]; prog[0] = tmp;
    corrupt0 = 1'b1;
    set_in(0, 0, 0, 0, 1, 0); cyc("par.rd0");
    chk("par.perr", 32'(ParityErr), 32'(PAR_EN));
    chk("par.valid", 32'(InstValid), 1);
    set_in(0, 0, 0, 0, 1, 5); cyc("par.halt");
    chk("par.haltperr", 32'(ParityErr), 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(0, 99) < 3, $urandom_range(0, 2) != 0, W'($urandom),
             $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)), A'($urandom_range(0, 7)));
      cyc("rand");
    end

    // Asynchronous reset in the middle of a load
    set_in(1, 0, 0, 0, 0, 0); cyc("ar.st");
    for (int b = 0; b < 3; b++) begin
      set_in(0, 1, W'($urandom), 0, 0, 0); cyc("ar.ld");
    end
    #3;
    Reset_n = 1'b0;
    #1;
    chk("ar.ready", 32'(LoadReady), 0);
    chk("ar.done",  32'(LoadDone),  0);
    chk("ar.count", 32'(LoadCount), 0);
    chk("ar.valid", 32'(InstValid), 0);
    chk("ar.out",   32'(InstOut),   0);
    chk("ar.perr",  32'(ParityErr), 0);
    set_in(0, 0, 0, 0, 0, 0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    mode = 0; prog.delete(); exp_out = '0;
    set_in(0, 0, 0, 0, 1, 0); cyc("ar.idle");
    chk("ar.idlecnt", 32'(LoadCount), 0);
    chk("ar.idlerdy", 32'(LoadReady), 0);
    chk("ar.idlev",   32'(InstValid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
